pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
- Sequences the board clock PLL: pulses the PLL reset, waits for lock with a timeout, qualifies lock stability, then releases the system reset.
- Detects loss of lock during operation and re-runs the sequence; counts retries for diagnostics.
- Runs entirely on the free-running reference clock (50 MHz), never on the PLL output.
- Sits between the board reset input and the PLL, and drives the SoC reset.

Parameters:
RESET_CYCLES, 16, refclk cycles pll_rst is held high per attempt (>=1)
LOCK_TIMEOUT, 50000, refclk cycles allowed in WAIT_LOCK before retry (1 ms at 50 MHz)
LOCK_STABLE, 1024, consecutive cycles of synchronized lock required before release
COUNT_W, 8, width of retry_count

Ports:
refclk  input  1  reference clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
pll_locked  input  1  PLL locked output, asynchronous; 2-flop synchronized internally
rearm  input  1  single-cycle request to re-run the full sequence
pll_rst  output  1  PLL reset, active high
sys_reset  output  1  system reset, active high; consumer synchronizes into outclk domain
ready  output  1  high while in RUN
timeout_err  output  1  one-cycle pulse when a lock attempt times out
retry_count  output  COUNT_W  saturating count of timeouts plus loss-of-lock events

Behaviour:
- Reset (rst=1 at edge): state=RESET_PLL, cnt=0, pll_rst=1, sys_reset=1, ready=0, timeout_err=0, retry_count=0, sync flops=0. rst has priority over every other input.
- lk = output of the second synchronizer flop (2-cycle latency from pll_locked).
- All outputs are registered. pll_rst=1 only in RESET_PLL. sys_reset=0 only in RUN. ready = (state==RUN).
- RESET_PLL: cnt increments each cycle. At cnt==RESET_CYCLES-1 -> WAIT_LOCK with cnt=0. pll_rst is high for exactly RESET_CYCLES cycles.
- WAIT_LOCK: cnt increments each cycle.
  - lk=1 -> STABLE with cnt=0.
  - Otherwise, at cnt==LOCK_TIMEOUT-1 -> RESET_PLL with cnt=0; timeout_err=1 for that cycle; retry_count+1.
  - If lk rises on the same cycle as the timeout, lk wins and no timeout is raised.
- STABLE: lk=1 increments cnt. At cnt==LOCK_STABLE-1 -> RUN.
  - lk=0 -> WAIT_LOCK with cnt=0. The timeout restarts and this is not counted as a retry.
- RUN: lk=0 (loss of lock) -> RESET_PLL with cnt=0; retry_count+1. sys_reset reasserts on the next cycle.
- rearm=1 in any state -> RESET_PLL with cnt=0. retry_count is unchanged.
  - rearm takes priority over the lock/timeout transitions on the same cycle.
  - rearm during RESET_PLL restarts that phase's count.
- retry_count saturates at 2^COUNT_W-1; only rst clears it.
- Counters are sized to clog2 of their largest terminal value.
- Minimum release latency, with pll_locked high from the start: RESET_CYCLES + 2 (sync) + LOCK_STABLE + 1 cycles after rst deasserts.

Optional Feature:
- Macro: PLL_SEQ_LOSS_FILTER_EN.
- Defined:
  - RUN treats lock as lost only after lk=0 for 4 consecutive cycles, tracked by a 2-bit filter counter. The counter clears on any lk=1 and on leaving RUN.
  - sys_reset reasserts on the cycle after the 4th low sample.
  - Shorter glitches are ignored and retry_count is unchanged.
- Not defined: loss of lock acts on the first lk=0 sample, as above.
- STABLE and WAIT_LOCK behave the same in both builds.

Test Plan (RESET_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, COUNT_W=8):
1. rst high 3 cycles, then low; pll_locked tied 1 -> pll_rst high for exactly 4 cycles after release; sys_reset falls and ready rises at cycle 4+2+8+1=15; retry_count=0.
2. pll_locked held 0 -> timeout_err pulses every 24 cycles (4 reset + 20 wait); retry_count reads 3 after the third pulse; sys_reset stays 1 throughout.
3. In RUN, drop pll_locked for 1 cycle (no macro) -> pll_rst reasserts 3 cycles later for 4 cycles; sys_reset=1; retry_count+1; with pll_locked back at 1, the sequence returns to RUN. With PLL_SEQ_LOSS_FILTER_EN: 3-cycle glitch -> ready stays 1; 4-cycle drop -> resequence.
4. In STABLE at cnt=5, pll_locked low 1 cycle -> returns to WAIT_LOCK; no timeout_err; ready delayed by a full 8 stable cycles after lock returns.
5. rearm pulse in RUN -> pll_rst=1 next cycle for 4 cycles; ready=0; retry_count unchanged. rearm on the same cycle as a WAIT_LOCK timeout -> no timeout_err, no count.
6. Force 260 timeouts -> retry_count saturates at 255; rst -> 0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer on the free-running reference clock: PLL reset pulse, lock wait with timeout,
// lock qualification, then system reset release. Optional macro PLL_SEQ_LOSS_FILTER_EN debounces loss of lock in RUN.
module pll_reset_sequencer #(
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_STABLE  = 1024,
  parameter int COUNT_W      = 8
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               rearm,
  output logic               pll_rst,
  output logic               sys_reset,
  output logic               ready,
  output logic               timeout_err,
  output logic [COUNT_W-1:0] retry_count
);

  localparam int MAX_AB = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_T  = ((MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE) - 1;
  localparam int CNT_W  = (MAX_T < 1) ? 1 : $clog2(MAX_T + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE - 1);

  typedef enum logic [1:0] {
    S_RESET_PLL = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COUNT_W-1:0] retry_q, retry_d;
  logic               sync1_q, sync1_d;
  logic               lk_q, lk_d;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_reset_q, sys_reset_d;
  logic               ready_q, ready_d;
  logic               timeout_q, timeout_d;
  logic               timeout_evt;
  logic               retry_evt;
`ifdef PLL_SEQ_LOSS_FILTER_EN
  logic [1:0]         filt_q, filt_d;
`endif

  // Lock reported while the PLL is held in reset is not trusted, so the synchronizer is flushed then.
  always_comb begin
    sync1_d = pll_locked & (state_q != S_RESET_PLL);
    lk_d    = sync1_q & (state_q != S_RESET_PLL);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      sync1_q     <= 1'b0;
      lk_q        <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef PLL_SEQ_LOSS_FILTER_EN
      filt_q      <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      sync1_q     <= sync1_d;
      lk_q        <= lk_d;
      pll_rst_q   <= pll_rst_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
      timeout_q   <= timeout_d;
`ifdef PLL_SEQ_LOSS_FILTER_EN
      filt_q      <= filt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    timeout_evt = 1'b0;
    retry_evt   = 1'b0;
`ifdef PLL_SEQ_LOSS_FILTER_EN
    filt_d      = 2'd0;
`endif
    if (rearm) begin
      state_d = S_RESET_PLL;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        S_WAIT_LOCK: begin
          // Lock arriving on the timeout cycle wins over the timeout.
          if (lk_q) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TMO_LAST) begin
            state_d     = S_RESET_PLL;
            cnt_d       = '0;
            timeout_evt = 1'b1;
            retry_evt   = 1'b1;
          end
        end
        S_STABLE: begin
          if (!lk_q) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STB_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end
        end
        S_RUN: begin
          cnt_d = '0;
`ifdef PLL_SEQ_LOSS_FILTER_EN
          if (!lk_q) begin
            if (filt_q == 2'd3) begin
              state_d   = S_RESET_PLL;
              retry_evt = 1'b1;
            end else begin
              filt_d = filt_q + 2'd1;
            end
          end
`else
          if (!lk_q) begin
            state_d   = S_RESET_PLL;
            retry_evt = 1'b1;
          end
`endif
        end
        default: begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end
    retry_d = (retry_evt && (retry_q != '1)) ? retry_q + COUNT_W'(1) : retry_q;
  end

  always_comb begin
    pll_rst_d   = (state_d == S_RESET_PLL);
    sys_reset_d = (state_d != S_RUN);
    ready_d     = (state_d == S_RUN);
    timeout_d   = timeout_evt;
  end

  assign pll_rst     = pll_rst_q;
  assign sys_reset   = sys_reset_q;
  assign ready       = ready_q;
  assign timeout_err = timeout_q;
  assign retry_count = retry_q;

endmodule
